// File: rtl/cpu_oam_dma.sv
// cpu_oam_dma: sprite DMA engine sitting between the 6502 core bus outputs
// and the system bus. A core write to P_DMA_REG halts the core and copies the
// 256-byte page {written byte, 8'h00} to P_OAM_DATA as alternating read/write
// bus cycles. When idle the block is a transparent pass-through.
//
// Optional feature macro: OAM_DMA_ALIGN_EN
//   defined   -> one ALIGN cycle is inserted after HALT when needed so that
//                every READ cycle runs with parity = 0.
//   undefined -> ALIGN is unreachable; every transfer takes 513 bus cycles.
module cpu_oam_dma #(
    parameter logic [15:0] P_DMA_REG  = 16'h4014,
    parameter logic [15:0] P_OAM_DATA = 16'h2004
) (
    input  logic        I_clock,
    input  logic        I_reset,
    input  logic [15:0] I_cpu_addr,
    input  logic [7:0]  I_cpu_wdata,
    input  logic        I_cpu_rdwr,
    input  logic        I_cpu_phy2,
    output logic        O_cpu_ready,
    input  logic [7:0]  I_bus_rdata,
    output logic [15:0] O_bus_addr,
    output logic [7:0]  O_bus_wdata,
    output logic        O_bus_rdwr,
    output logic        O_dma_active
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [7:0]  page;
    logic [7:0]  count;
    logic [7:0]  latch;
    logic        parity;
    logic        last_phy2;
    logic        strobe;
    logic        trigger_hit;
    logic        need_align;
    logic        last_byte;

    // A bus cycle ends on the registered falling edge of phi2; every state
    // update in this block is qualified by this single-clock strobe.
    assign strobe = last_phy2 & ~I_cpu_phy2;

    // Only a core write to the DMA register starts a transfer; reads of the
    // same address fall through as ordinary bus traffic.
    assign trigger_hit = ~I_cpu_rdwr && (I_cpu_addr == P_DMA_REG);

    // The final byte of the page has been written when count is 8'hFF.
    assign last_byte = (count == 8'hFF);

    // parity is sampled before its toggle on the HALT-ending strobe, so the
    // post-toggle value is ~parity. ALIGN is taken when that value is 1,
    // which leaves every READ cycle starting with parity = 0.
`ifdef OAM_DMA_ALIGN_EN
    assign need_align = ~parity;
`else
    assign need_align = 1'b0;
`endif

    // phi2 edge detector: runs every clock so the strobe is one clock wide.
    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            last_phy2 <= 1'b0;
        end else begin
            last_phy2 <= I_cpu_phy2;
        end
    end

    // State register: advances only at the end of a bus cycle.
    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            state <= ST_IDLE;
        end else if (strobe) begin
            state <= next_state;
        end
    end

    // Next-state logic for the idle / halt / align / read / write sequence.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (trigger_hit) begin
                    next_state = ST_HALT;
                end
            end
            ST_HALT: begin
                next_state = need_align ? ST_ALIGN : ST_READ;
            end
            ST_ALIGN: begin
                next_state = ST_READ;
            end
            ST_READ: begin
                next_state = ST_WRITE;
            end
            ST_WRITE: begin
                next_state = last_byte ? ST_IDLE : ST_READ;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Transfer datapath: source page, byte counter, read-data latch and the
    // free-running bus-cycle parity (cleared only by reset).
    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            page   <= 8'h00;
            count  <= 8'h00;
            latch  <= 8'h00;
            parity <= 1'b0;
        end else if (strobe) begin
            parity <= ~parity;
            case (state)
                ST_IDLE: begin
                    if (trigger_hit) begin
                        page  <= I_cpu_wdata;
                        count <= 8'h00;
                    end
                end
                ST_READ: begin
                    latch <= I_bus_rdata;
                end
                ST_WRITE: begin
                    // 8-bit wrap keeps the source address inside the page.
                    count <= count + 8'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode from the registered state. In IDLE the core owns the bus
    // combinationally; HALT/ALIGN present the core address as a dummy read.
    always_comb begin
        O_bus_addr  = I_cpu_addr;
        O_bus_wdata = I_cpu_wdata;
        O_bus_rdwr  = I_cpu_rdwr;
        O_cpu_ready = 1'b1;
        case (state)
            ST_IDLE: begin
                O_bus_addr  = I_cpu_addr;
                O_bus_wdata = I_cpu_wdata;
                O_bus_rdwr  = I_cpu_rdwr;
                O_cpu_ready = 1'b1;
            end
            ST_HALT, ST_ALIGN: begin
                O_bus_addr  = I_cpu_addr;
                O_bus_wdata = I_cpu_wdata;
                O_bus_rdwr  = 1'b1;
                O_cpu_ready = 1'b0;
            end
            ST_READ: begin
                O_bus_addr  = {page, count};
                O_bus_wdata = latch;
                O_bus_rdwr  = 1'b1;
                O_cpu_ready = 1'b0;
            end
            ST_WRITE: begin
                O_bus_addr  = P_OAM_DATA;
                O_bus_wdata = latch;
                O_bus_rdwr  = 1'b0;
                O_cpu_ready = 1'b0;
            end
            default: begin
                O_bus_addr  = I_cpu_addr;
                O_bus_wdata = I_cpu_wdata;
                O_bus_rdwr  = I_cpu_rdwr;
                O_cpu_ready = 1'b1;
            end
        endcase
        O_dma_active = ~O_cpu_ready;
    end

endmodule
